relu_maxpool2x2: RTL and testbench
==================================

Name: relu_maxpool2x2

Overview:
Streaming post-processing stage directly downstream of the MAC accumulator. It consumes finished convolution outputs for one feature map in raster order, one Q-format value per valid cycle. It applies ReLU and 2x2 stride-2 max pooling, and emits one pooled value per 2x2 window to the next layer's input buffer. A half-width line buffer holds the row-pair partial maxima.

Parameters:
N, 16, total data width (signed fixed point)
Q, 8, fractional bits (pass-through only; no rescaling performed)
IMG_W, 24, input feature-map width in pixels; must be even and >= 2
IMG_H, 24, input feature-map height in pixels; must be even and >= 2

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
in_valid  in  1  in_data carries a valid accumulator result this cycle
in_sof  in  1  start of frame; qualifies in_valid, marks pixel (row 0, col 0)
in_data  in  N  signed Q-format conv result from MAC
out_valid  out  1  out_data valid this cycle (single-cycle pulse per pooled pixel)
out_data  out  N  signed pooled value, always >= 0 after ReLU
out_last  out  1  high with out_valid on the final pooled pixel of the frame
frame_done  out  1  one-cycle pulse, same cycle as out_last

Behaviour:
- Clocking: one clock domain (clk). Reset is synchronous and active-high (reset); all state changes on the rising edge of clk.
- Reset: out_valid=0, out_data=0, out_last=0, frame_done=0; col=0, row=0, pair register cleared. Line buffer contents are don't-care and are never read before being written in the current frame.
- Counters: col runs 0..IMG_W-1 and row runs 0..IMG_H-1. Both advance only on in_valid.
  - col wraps to 0 at IMG_W-1 and increments row.
  - row wraps to 0 at IMG_H-1, so the next frame is accepted without in_sof.
- in_sof: in_valid && in_sof forces the current pixel to (0,0), abandoning any partial frame. No output is produced for an abandoned window. When in_valid=0, in_sof is ignored.
- Gaps: in_valid may drop for any number of cycles. All state holds; no timeout.
- Pair stage: on even col, register the pixel in pair_reg. On odd col, pair_max = signed max(pair_reg, in_data).
- Even row, odd col: line_buf[col>>1] <= pair_max. No output.
- Odd row, odd col: win_max = signed max(pair_max, line_buf[col>>1]). Then out_data <= (win_max < 0) ? 0 : win_max, and out_valid <= 1 on the next edge.
- Latency: out_valid asserts exactly one cycle after the accepted pixel that completes the window (bottom-right).
- Output spacing: at most one output per 2 input pixels, so no backpressure is needed. The downstream consumer must accept every out_valid.
- out_last/frame_done: asserted with the output of window (row IMG_H-1, col IMG_W-1); low otherwise.
- Pooled frame: (IMG_W/2) x (IMG_H/2) outputs, raster order.
- Arithmetic: comparisons are signed N-bit; no saturation or width growth. Equal values select either operand (identical result).
- Line buffer: IMG_W/2 x N bits, single write port and single read port, read addressed by col>>1. A register array or inferred distributed RAM is acceptable; the read must be combinational or pre-fetched so latency stays at 1.
- Reset mid-frame: counters return to (0,0). Any pending out_valid is cancelled on that edge and no stale output is emitted afterwards.
- Simultaneous reset and in_valid: reset wins; the pixel is dropped.

Test Plan:
1. IMG_W=4, IMG_H=2, Q=8.
   - Stimulus: row0 = 0x0100, 0xFF00, 0x0080, 0x0040; row1 = 0x0000, 0x0200, 0xFE00, 0xFF80; in_sof on the first pixel.
   - Response: out 0x0200, then 0x0080.
   - Each output arrives 1 cycle after pixel 6 and pixel 8 respectively. out_last and frame_done are high on the 2nd output only.
2. All-negative window (-1.0, -0.5, -2.0, -0.25) -> out_data=0x0000 with out_valid=1.
3. Same frame as test 1 with random in_valid gaps of 0-5 cycles.
   - Response: identical output values and order; each out_valid lands 1 cycle after its window-completing pixel.
4. Back-to-back frames, no in_sof on the second.
   - Response: the second frame produces correct outputs, and out_last fires once per frame.
5. Reset asserted after row0 col2 of a frame, then a fresh frame.
   - Response: no output is produced from the aborted data, and the fresh frame matches golden.
6. Default 24x24 with random signed data.
   - Response: 144 outputs matching a software ReLU+maxpool model, exactly one out_last.
   - Also: in_sof mid-frame restarts the window alignment.

Source files
------------

// File: rtl/relu_maxpool2x2.sv
`default_nettype none
// relu_maxpool2x2 -- streaming ReLU + 2x2 stride-2 max pooling over a raster-order feature map.
// Rev 1.0
module relu_maxpool2x2 #(
  parameter int N     = 16,
  parameter int Q     = 8,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  input  logic         in_sof,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         out_last,
  output logic         frame_done
);

  localparam int CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int AW    = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam int DEPTH = IMG_W / 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  generate
    if ((IMG_W % 2 != 0) || (IMG_H % 2 != 0) || (IMG_W < 2) || (IMG_H < 2) || (Q >= N)) begin : g_bad_params
      $error("relu_maxpool2x2: IMG_W/IMG_H must be even and >= 2, Q must be < N");
    end
  endgenerate

  logic [CW-1:0]        col, cur_col;
  logic [RW-1:0]        row, cur_row;
  logic [AW-1:0]        lb_idx;
  logic signed [N-1:0]  pair_reg, pair_max, lb_rd, win_max, relu_val;
  logic signed [N-1:0]  line_buf [DEPTH];
  logic                 col_wrap, row_wrap;

  // A start-of-frame pixel is treated as (0,0) regardless of the running counters.
  always_comb begin
    cur_col  = in_sof ? '0 : col;
    cur_row  = in_sof ? '0 : row;
    col_wrap = (cur_col == COL_LAST);
    row_wrap = (cur_row == ROW_LAST);
    lb_idx   = AW'(cur_col >> 1);
    lb_rd    = line_buf[lb_idx];
    pair_max = ($signed(in_data) > pair_reg) ? $signed(in_data) : pair_reg;
    win_max  = (pair_max > lb_rd) ? pair_max : lb_rd;
    relu_val = win_max[N-1] ? '0 : win_max;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      pair_reg   <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        if (!cur_col[0]) begin
          pair_reg <= $signed(in_data);
        end else if (cur_row[0]) begin
          out_valid  <= 1'b1;
          out_data   <= relu_val;
          out_last   <= col_wrap && row_wrap;
          frame_done <= col_wrap && row_wrap;
        end
        if (col_wrap) begin
          col <= '0;
          row <= row_wrap ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
      end
    end
  end

  // Row-pair maxima from the even row; never read before written within a frame.
  always_ff @(posedge clk) begin
    if (!reset && in_valid && cur_col[0] && !cur_row[0]) begin
      line_buf[lb_idx] <= pair_max;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool2x2.sv
`default_nettype none
// tb_relu_maxpool2x2 -- scoreboard bench: a 4x2 instance for directed frames, a 24x24 instance for a random frame.
module tb_relu_maxpool2x2;
  localparam int N = 16;
  localparam int LW = 24;
  localparam int LH = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] d;
    logic         last;
    int           cyc;
  } exp_t;

  exp_t sq[$];
  exp_t lq[$];

  logic         s_rst, s_valid, s_sof, s_out_valid, s_out_last, s_frame_done;
  logic [N-1:0] s_data, s_out_data;
  logic         l_rst, l_valid, l_sof, l_out_valid, l_out_last, l_frame_done;
  logic [N-1:0] l_data, l_out_data;
  int           l_out_cnt = 0;
  int           l_last_cnt = 0;

  relu_maxpool2x2 #(.N(N), .Q(8), .IMG_W(4), .IMG_H(2)) dut_s (
    .clk(clk), .reset(s_rst), .in_valid(s_valid), .in_sof(s_sof), .in_data(s_data),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_last(s_out_last), .frame_done(s_frame_done)
  );

  relu_maxpool2x2 #(.N(N), .Q(8), .IMG_W(LW), .IMG_H(LH)) dut_l (
    .clk(clk), .reset(l_rst), .in_valid(l_valid), .in_sof(l_sof), .in_data(l_data),
    .out_valid(l_out_valid), .out_data(l_out_data), .out_last(l_out_last), .frame_done(l_frame_done)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (s_out_valid) begin
      if (sq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s_unexpected: out_data=%h at cycle %0d, none expected", s_out_data, cyc);
      end else begin
        exp_t e;
        e = sq.pop_front();
        checks++;
        if (s_out_data !== e.d || s_out_last !== e.last || s_frame_done !== e.last || cyc != e.cyc) begin
          errors++;
          $display("FAIL s_output: data=%h last=%b done=%b cyc=%0d expected data=%h last=%b done=%b cyc=%0d",
                   s_out_data, s_out_last, s_frame_done, cyc, e.d, e.last, e.last, e.cyc);
        end
      end
    end else if (s_out_last || s_frame_done) begin
      checks++;
      errors++;
      $display("FAIL s_stray_last: last=%b done=%b without out_valid, expected 0 0", s_out_last, s_frame_done);
    end
  end

  always @(negedge clk) begin
    if (l_out_valid) begin
      l_out_cnt++;
      if (l_out_last) l_last_cnt++;
      if (lq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL l_unexpected: out_data=%h at cycle %0d, none expected", l_out_data, cyc);
      end else begin
        exp_t e;
        e = lq.pop_front();
        checks++;
        if (l_out_data !== e.d || l_out_last !== e.last || l_frame_done !== e.last || cyc != e.cyc) begin
          errors++;
          $display("FAIL l_output: data=%h last=%b done=%b cyc=%0d expected data=%h last=%b done=%b cyc=%0d",
                   l_out_data, l_out_last, l_frame_done, cyc, e.d, e.last, e.last, e.cyc);
        end
      end
    end else if (l_out_last || l_frame_done) begin
      checks++;
      errors++;
      $display("FAIL l_stray_last: last=%b done=%b without out_valid, expected 0 0", l_out_last, l_frame_done);
    end
  end

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic drive_s(input logic [N-1:0] d, input logic sof, input bit ex,
                         input logic [N-1:0] ev, input logic el, input int gmax);
    int g;
    g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    repeat (g) @(negedge clk);
    s_valid = 1'b1;
    s_sof   = sof;
    s_data  = d;
    if (ex) sq.push_back('{d: ev, last: el, cyc: cyc + 1});
    @(negedge clk);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic frame_s(input logic [N-1:0] px [8], input logic [N-1:0] e0, input logic [N-1:0] e1,
                         input bit sof, input int gmax);
    for (int i = 0; i < 8; i++)
      drive_s(px[i], sof && (i == 0), (i == 5) || (i == 7), (i == 5) ? e0 : e1, i == 7, gmax);
  endtask

  task automatic reset_s_with_pixel(input logic [N-1:0] d);
    s_rst   = 1'b1;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    check("s_reset_valid", int'(s_out_valid), 0);
    check("s_reset_data", int'(s_out_data), 0);
    s_rst   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic drive_l(input logic [N-1:0] d, input logic sof, input bit ex,
                         input logic [N-1:0] ev, input logic el, input int gmax);
    int g;
    g = (gmax > 0) ? int'($urandom_range(gmax, 0)) : 0;
    repeat (g) @(negedge clk);
    l_valid = 1'b1;
    l_sof   = sof;
    l_data  = d;
    if (ex) lq.push_back('{d: ev, last: el, cyc: cyc + 1});
    @(negedge clk);
    l_valid = 1'b0;
    l_sof   = 1'b0;
  endtask

  logic [N-1:0] fa [8];
  logic [N-1:0] fn [8];
  logic [N-1:0] fb [8];
  logic signed [N-1:0] pix [LH][LW];

  initial begin
    logic signed [N-1:0] m;
    fa = '{16'h0100, 16'hFF00, 16'h0080, 16'h0040, 16'h0000, 16'h0200, 16'hFE00, 16'hFF80};
    fn = '{16'hFF00, 16'hFF80, 16'h0010, 16'h8000, 16'hFE00, 16'hFFC0, 16'h7FFF, 16'h0001};
    fb = '{16'h0300, 16'h0100, 16'hFFFF, 16'hFFFE, 16'h0001, 16'h0002, 16'h8000, 16'h8001};
    s_rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0;
    l_rst = 1'b1; l_valid = 1'b0; l_sof = 1'b0; l_data = '0;
    repeat (2) @(negedge clk);
    check("s_rst_out_valid", int'(s_out_valid), 0);
    check("s_rst_out_data", int'(s_out_data), 0);
    check("s_rst_out_last", int'(s_out_last), 0);
    check("s_rst_frame_done", int'(s_frame_done), 0);
    check("l_rst_out_valid", int'(l_out_valid), 0);
    check("l_rst_frame_done", int'(l_frame_done), 0);
    s_rst = 1'b0;
    l_rst = 1'b0;

    // Basic frame, then all-negative window plus extreme values
    frame_s(fa, 16'h0200, 16'h0080, 1'b1, 0);
    frame_s(fn, 16'h0000, 16'h7FFF, 1'b1, 0);
    // Random input gaps
    frame_s(fa, 16'h0200, 16'h0080, 1'b1, 5);
    // Back-to-back frames, second without sof
    frame_s(fa, 16'h0200, 16'h0080, 1'b1, 0);
    frame_s(fb, 16'h0300, 16'h0000, 1'b0, 0);

    // Reset after row0 col2 (with a simultaneous pixel), then fresh frame without sof
    for (int i = 0; i < 3; i++) drive_s(fa[i], i == 0, 1'b0, '0, 1'b0, 0);
    reset_s_with_pixel(16'h7FFF);
    frame_s(fa, 16'h0200, 16'h0080, 1'b0, 0);
    // Reset coinciding with a window-completing pixel drops it
    for (int i = 0; i < 5; i++) drive_s(fa[i], 1'b0, 1'b0, '0, 1'b0, 0);
    reset_s_with_pixel(fa[5]);
    @(negedge clk);
    check("s_dropped_pixel_no_output", int'(s_out_valid), 0);
    frame_s(fb, 16'h0300, 16'h0000, 1'b0, 1);

    // Large frame: abandoned partial row, then sof restart with random data
    for (int i = 0; i < 17; i++) drive_l(16'($urandom), i == 0, 1'b0, '0, 1'b0, 0);
    for (int r = 0; r < LH; r++) begin
      for (int c = 0; c < LW; c++) begin
        pix[r][c] = 16'($urandom);
        m = '0;
        if (r % 2 == 1 && c % 2 == 1) begin
          m = pix[r-1][c-1];
          if (pix[r-1][c] > m) m = pix[r-1][c];
          if (pix[r][c-1] > m) m = pix[r][c-1];
          if (pix[r][c] > m) m = pix[r][c];
          if (m < 0) m = '0;
        end
        drive_l(pix[r][c], (r == 0) && (c == 0), (r % 2 == 1) && (c % 2 == 1), m,
                (r == LH - 1) && (c == LW - 1), 1);
      end
    end

    repeat (20) @(negedge clk);
    check("s_missing_outputs", sq.size(), 0);
    check("l_missing_outputs", lq.size(), 0);
    check("l_output_count", l_out_cnt, (LW / 2) * (LH / 2));
    check("l_out_last_count", l_last_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
